// File: rtl/aes_key_schedule_pkg.sv
// Shared definitions for the AES-128 key schedule.
//   AES_NUM_ROUNDS : last round index for AES-128
//   state_t        : key-schedule FSM states (IDLE, GEN)
//   rcon()         : round constant for the round being produced (1..10)
//   gf_mul()       : GF(2^8) multiply modulo x^8+x^4+x^3+x+1, used by the S-box
package aes_key_schedule_pkg;

  localparam int unsigned AES_NUM_ROUNDS = 10;

  typedef enum logic {
    IDLE = 1'b0,
    GEN  = 1'b1
  } state_t;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] c;
    case (r)
      4'd1:    c = 8'h01;
      4'd2:    c = 8'h02;
      4'd3:    c = 8'h04;
      4'd4:    c = 8'h08;
      4'd5:    c = 8'h10;
      4'd6:    c = 8'h20;
      4'd7:    c = 8'h40;
      4'd8:    c = 8'h80;
      4'd9:    c = 8'h1b;
      4'd10:   c = 8'h36;
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

endpackage

// File: rtl/aes_key_schedule_sbox.sv
// aes_sbox: combinational AES forward S-box for one byte.
//   value  : input byte
//   result : S-box substitution of value
// Computed as multiplicative inverse in GF(2^8) followed by the AES affine
// transform; shared by SubWord here and by SubBytes in the cipher datapath.
module aes_sbox
  import aes_key_schedule_pkg::*;
(
  input  logic [7:0] value,
  output logic [7:0] result
);

  logic [7:0] sq;
  logic [7:0] inv;

  // inverse as value^254 = value^2 * value^4 * ... * value^128; maps 0 to 0
  always_comb begin
    sq  = value;
    inv = 8'h01;
    for (int unsigned k = 1; k < 8; k++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
  end

  assign result = inv
                ^ {inv[6:0], inv[7]}
                ^ {inv[5:0], inv[7:6]}
                ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]}
                ^ 8'h63;

endmodule

// File: rtl/aes_key_schedule.sv
// aes_key_schedule: iterative AES-128 key expansion, one round key per
// accepted output handshake (round keys 0..NUM_ROUNDS).
//   clk, reset       : rising-edge clock, synchronous active-high reset
//   key_valid_in     : cipher key on key_in is valid (captured only in IDLE)
//   key_in           : cipher key, key_in[127:96] = w0
//   key_ready        : block can accept a new cipher key
//   round_key_ready  : downstream accepts current round key
//   round_key_valid  : round_key / round_idx valid
//   round_key        : current round key (registered)
//   round_idx        : index of round_key
//   round_last       : valid final round key
module aes_key_schedule
  import aes_key_schedule_pkg::*;
#(
  parameter int unsigned DATA_LEN   = 128,
  parameter int unsigned NUM_ROUNDS = AES_NUM_ROUNDS,
  parameter int unsigned IDX_W      = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                key_valid_in,
  input  logic [DATA_LEN-1:0] key_in,
  output logic                key_ready,
  input  logic                round_key_ready,
  output logic                round_key_valid,
  output logic [DATA_LEN-1:0] round_key,
  output logic [IDX_W-1:0]    round_idx,
  output logic                round_last
);

  state_t              state_q;
  state_t              state_d;
  logic [DATA_LEN-1:0] key_q;
  logic [IDX_W-1:0]    idx_q;
  logic [IDX_W-1:0]    idx_next;
  logic                last_idx;
  logic                load;
  logic                advance;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot;
  logic [31:0] sub;
  logic [31:0] t;
  logic [31:0] n0, n1, n2, n3;

  assign last_idx = (idx_q == IDX_W'(NUM_ROUNDS));
  assign idx_next = idx_q + IDX_W'(1);

  // next-round key network
  assign {w0, w1, w2, w3} = key_q;
  assign rot = {w3[23:0], w3[31:24]};

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .value  (rot[8*i +: 8]),
      .result (sub[8*i +: 8])
    );
  end

  assign t  = sub ^ {rcon(4'(idx_next)), 24'h000000};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    key_ready       = 1'b0;
    round_key_valid = 1'b0;
    case (state_q)
      IDLE: begin
        key_ready = 1'b1;
        if (key_valid_in) state_d = GEN;
      end
      GEN: begin
        round_key_valid = 1'b1;
        if (round_key_ready && last_idx) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign load    = key_ready && key_valid_in;
  // the final transfer only leaves GEN, so idx never exceeds NUM_ROUNDS
  assign advance = round_key_valid && round_key_ready && !last_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_q <= '0;
      idx_q <= '0;
    end else if (load) begin
      key_q <= key_in;
      idx_q <= '0;
    end else if (advance) begin
      key_q <= {n0, n1, n2, n3};
      idx_q <= idx_next;
    end
  end

  assign round_key  = key_q;
  assign round_idx  = idx_q;
  assign round_last = round_key_valid && last_idx;

endmodule

// File: tb/tb_aes_key_schedule.sv
module tb_aes_key_schedule;

  logic         clk = 1'b0;
  logic         reset;
  logic         key_valid_in;
  logic [127:0] key_in;
  logic         key_ready;
  logic         round_key_ready;
  logic         round_key_valid;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         round_last;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;

  logic [127:0] exp_keys [11];
  logic [127:0] got      [11];

  logic [7:0] sbox_tab [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  logic [7:0] rcon_tab [11] = '{8'h00,8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36};

  aes_key_schedule #(
    .DATA_LEN   (128),
    .NUM_ROUNDS (10),
    .IDX_W      (4)
  ) u_dut (
    .clk             (clk),
    .reset           (reset),
    .key_valid_in    (key_valid_in),
    .key_in          (key_in),
    .key_ready       (key_ready),
    .round_key_ready (round_key_ready),
    .round_key_valid (round_key_valid),
    .round_key       (round_key),
    .round_idx       (round_idx),
    .round_last      (round_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // FIPS-197 word-array key expansion
  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]], sbox_tab[t[7:0]]};
        t[31:24] = t[31:24] ^ rcon_tab[i/4];
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // Offers key, then consumes round keys with random backpressure.
  // hold keeps key_valid_in high with other_key during generation.
  // abort_at >= 0 asserts reset when that round index is presented.
  task automatic expand(input logic [127:0] key, input int unsigned ready_pct,
                        input bit hold, input logic [127:0] other_key, input int abort_at,
                        output int unsigned acc_cyc, output int unsigned valid_cycles);
    int unsigned k;
    int unsigned guard;
    bit          rdy;
    model_expand(key);
    acc_cyc      = 0;
    valid_cycles = 0;
    guard = 0;
    while (key_ready !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (key_ready !== 1'b1) begin
      check("key_ready_timeout", {127'b0, key_ready}, 128'd1);
      return;
    end
    key_valid_in = 1'b1;
    key_in       = key;
    @(negedge clk);
    acc_cyc = cyc;
    if (hold) key_in = other_key;
    else key_valid_in = 1'b0;
    k = 0;
    guard = 0;
    while (k <= 10 && guard < 300) begin
      check("gen_key_ready", {127'b0, key_ready}, 128'd0);
      check("gen_valid", {127'b0, round_key_valid}, 128'd1);
      check("round_idx", {124'b0, round_idx}, 128'(k));
      check("round_key", round_key, exp_keys[k]);
      check("round_last", {127'b0, round_last}, {127'b0, (k == 10)});
      got[k] = round_key;
      valid_cycles++;
      if (abort_at >= 0 && k == abort_at) begin
        reset           = 1'b1;
        round_key_ready = 1'b1;
        @(negedge clk);
        reset           = 1'b0;
        round_key_ready = 1'b0;
        check("abort_key_ready", {127'b0, key_ready}, 128'd1);
        check("abort_valid", {127'b0, round_key_valid}, 128'd0);
        check("abort_round_key", round_key, 128'd0);
        check("abort_round_idx", {124'b0, round_idx}, 128'd0);
        return;
      end
      rdy = ($urandom_range(99) < ready_pct);
      round_key_ready = rdy;
      @(negedge clk);
      if (rdy) k++;
      guard++;
    end
    round_key_ready = 1'b0;
    if (k <= 10) check("gen_timeout", 128'(k), 128'd11);
    check("done_valid", {127'b0, round_key_valid}, 128'd0);
    check("done_key_ready", {127'b0, key_ready}, 128'd1);
    check("done_last", {127'b0, round_last}, 128'd0);
  endtask

  int unsigned  acc_a, acc_b, vc;
  logic [127:0] k1, k2;

  initial begin
    reset           = 1'b1;
    key_valid_in    = 1'b0;
    key_in          = '0;
    round_key_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_key_ready", {127'b0, key_ready}, 128'd1);
    check("rst_valid", {127'b0, round_key_valid}, 128'd0);
    check("rst_round_key", round_key, 128'd0);
    check("rst_round_idx", {124'b0, round_idx}, 128'd0);
    check("rst_last", {127'b0, round_last}, 128'd0);

    // known vector, no backpressure
    k1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    expand(k1, 100, 1'b0, '0, -1, acc_a, vc);
    check("fips_idx0", got[0], k1);
    check("fips_idx1", got[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("fips_idx10", got[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check("consecutive_valid", 128'(vc), 128'd11);

    // same key, random backpressure
    expand(k1, 50, 1'b0, '0, -1, acc_a, vc);

    // second key held during generation is ignored, then accepted afterwards
    k2 = {$urandom, $urandom, $urandom, $urandom};
    expand(k1, 70, 1'b1, k2, -1, acc_a, vc);
    check("held_key_valid", {127'b0, key_valid_in}, 128'd1);
    expand(k2, 70, 1'b0, '0, -1, acc_a, vc);
    check("second_idx0", got[0], k2);

    // reset mid-expansion then restart
    expand({$urandom, $urandom, $urandom, $urandom}, 100, 1'b0, '0, 5, acc_a, vc);
    expand({$urandom, $urandom, $urandom, $urandom}, 100, 1'b0, '0, -1, acc_a, vc);

    // all-zero key
    expand('0, 80, 1'b0, '0, -1, acc_a, vc);
    check("zero_idx1", got[1], 128'h62636363626363636263636362636363);
    check("zero_idx10", got[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // back-to-back keys
    expand({$urandom, $urandom, $urandom, $urandom}, 100, 1'b0, '0, -1, acc_a, vc);
    expand({$urandom, $urandom, $urandom, $urandom}, 100, 1'b0, '0, -1, acc_b, vc);
    check("b2b_gap", 128'(acc_b - acc_a), 128'd12);

    // random keys and backpressure
    for (int n = 0; n < 6; n++)
      expand({$urandom, $urandom, $urandom, $urandom}, $urandom_range(30, 100), 1'b0, '0, -1, acc_a, vc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
